keypad_entry_ctrl: RTL and testbench

Sequences writes from the 12-key keypad into the 8-digit seven-segment register file.
- Debounces key press and key release; each physical press produces exactly one action.
- Decodes digit keys to 7-bit segment patterns and drives a single write port (enable, address, data) into the register file.
- Maintains the digit cursor and generates the commit strobe (Out_en equivalent) consumed by the display path.

---
 rtl/keypad_entry_ctrl.sv | 153 +++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_ctrl.sv
// Keypad-to-display write sequencer: debounces press/release, decodes digits to segments.
// Optional build macro AUTO_ADVANCE_EN: advance the cursor after every digit write.
module keypad_entry_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned DIGITS          = 8,
  parameter int unsigned SEG_W           = 7,
  localparam int unsigned AW             = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [11:0]      key_in,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [SEG_W-1:0] wr_data,
  output logic             commit,
  output logic [AW-1:0]    cursor,
  output logic             err,
  output logic             busy
);

  localparam logic [7:0]    CntLast   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW-1:0] CursorMax = AW'(DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StDeb, StAct, StWaitRel} state_e;

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [11:0]      key_q, key_d;
  logic             wr_en_q, wr_en_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [SEG_W-1:0] wr_data_q, wr_data_d;
  logic             commit_q, commit_d;
  logic             err_q, err_d;
  logic [AW-1:0]    cursor_q, cursor_d;
  logic [AW-1:0]    cursor_inc;

  // Bits [8:0] are digits 1..9, bit 9 is digit 0; pattern order is {a,b,c,d,e,f,g}.
  function automatic logic [6:0] seg_of(input logic [11:0] k);
    logic [6:0] s;
    case (k)
      12'h001: s = 7'b0110000;
      12'h002: s = 7'b1101101;
      12'h004: s = 7'b1111001;
      12'h008: s = 7'b0110011;
      12'h010: s = 7'b1011011;
      12'h020: s = 7'b1011111;
      12'h040: s = 7'b1110010;
      12'h080: s = 7'b1111111;
      12'h100: s = 7'b1111011;
      12'h200: s = 7'b1111110;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  assign cursor_inc = (cursor_q >= CursorMax) ? '0 : cursor_q + AW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    wr_en_d   = 1'b0;
    commit_d  = 1'b0;
    err_d     = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cursor_d  = cursor_q;
    unique case (state_q)
      StIdle: begin
        if (key_in != '0) begin
          key_d   = key_in;
          cnt_d   = 8'd1;
          state_d = StDeb;
        end
      end
      StDeb: begin
        if (key_in != key_q) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q >= CntLast) begin
          // Action is registered on entry to StAct so strobes are high during that cycle.
          state_d = StAct;
          if (!$onehot(key_q)) begin
            err_d = 1'b1;
          end else if (key_q[11]) begin
            cursor_d = cursor_inc;
          end else if (key_q[10]) begin
            commit_d = 1'b1;
            cursor_d = '0;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = cursor_q;
            wr_data_d = SEG_W'(seg_of(key_q));
`ifdef AUTO_ADVANCE_EN
            cursor_d  = cursor_inc;
`else
            cursor_d  = cursor_q;
`endif
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StAct: begin
        cnt_d   = '0;
        state_d = StWaitRel;
      end
      StWaitRel: begin
        if (key_in != '0) begin
          cnt_d = '0;
        end else if (cnt_q >= CntLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StWaitRel;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StWaitRel;
      cnt_q     <= '0;
      key_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      commit_q  <= 1'b0;
      err_q     <= 1'b0;
      cursor_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      commit_q  <= commit_d;
      err_q     <= err_d;
      cursor_q  <= cursor_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign commit  = commit_q;
  assign err     = err_q;
  assign cursor  = cursor_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Scoreboard bench for keypad_entry_ctrl: run-length reference model plus randomized key traffic.
module tb_keypad_entry_ctrl;

  localparam int D      = 4;
  localparam int DIGITS = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] key_in = '0;
  logic        wr_en, commit, err, busy;
  logic [2:0]  wr_addr, cursor;
  logic [6:0]  wr_data;

  keypad_entry_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .DIGITS         (DIGITS),
    .SEG_W          (7)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .key_in (key_in),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .commit (commit),
    .cursor (cursor),
    .err    (err),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;  // 0 write, 1 commit, 2 err
    int cyc;
  } ev_t;
  ev_t sbq[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: "armed" means released long enough; candidate is a run of one key value.
  bit          armed = 1'b0;
  bit          skip = 1'b0;
  int          rel_len = 0;
  int          cand_len = 0;
  logic [11:0] cand = '0;
  int          m_cursor = 0;
  int          m_addr = 0;
  logic [6:0]  m_data = '0;
  logic [6:0]  pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                            7'b1011011, 7'b1011111, 7'b1110010, 7'b1111111, 7'b1111011};

  task automatic fire(input logic [11:0] k);
    int  idx = 0;
    ev_t e;
    for (int i = 0; i < 12; i++) if (k[i]) idx = i;
    e.cyc = cyc;
    if ($countones(k) != 1) begin
      e.kind = 2;
      sbq.push_back(e);
    end else if (idx == 11) begin
      m_cursor = (m_cursor + 1) % DIGITS;
    end else if (idx == 10) begin
      e.kind = 1;
      sbq.push_back(e);
      m_cursor = 0;
    end else begin
      e.kind = 0;
      sbq.push_back(e);
      m_addr = m_cursor;
      m_data = pat[(idx == 9) ? 0 : idx + 1];
`ifdef AUTO_ADVANCE_EN
      m_cursor = (m_cursor + 1) % DIGITS;
`endif
    end
    armed = 1'b0;
    skip = 1'b1;
    rel_len = 0;
    cand_len = 0;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      armed = 1'b0; skip = 1'b0; rel_len = 0; cand_len = 0;
      m_cursor = 0; m_addr = 0; m_data = '0;
    end else if (!armed) begin
      if (skip) skip = 1'b0;
      else if (key_in == '0) begin
        rel_len++;
        if (rel_len == D) armed = 1'b1;
      end else rel_len = 0;
    end else if (cand_len == 0) begin
      if (key_in != '0) begin
        cand = key_in;
        cand_len = 1;
      end
    end else if (key_in == cand) begin
      cand_len++;
      if (cand_len == D) fire(cand);
    end else begin
      cand_len = 0;  // mismatching sample is consumed by the abort
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      logic exp_busy;
      ev_t  e;
      int   kind;
      exp_busy = !(armed && cand_len == 0);
      checks++;
      if (busy !== exp_busy) begin
        failures++;
        $display("FAIL busy cyc=%0d got=%0b want=%0b", cyc, busy, exp_busy);
      end
      checks++;
      if (cursor !== 3'(m_cursor)) begin
        failures++;
        $display("FAIL cursor cyc=%0d got=%0d want=%0d", cyc, cursor, m_cursor);
      end
      checks++;
      if (wr_addr !== 3'(m_addr) || wr_data !== m_data) begin
        failures++;
        $display("FAIL wr_port cyc=%0d got=%0d/%b want=%0d/%b", cyc, wr_addr, wr_data,
                 m_addr, m_data);
      end
      if (wr_en || commit || err) begin
        kind = wr_en ? 0 : (commit ? 1 : 2);
        checks++;
        if (int'(wr_en) + int'(commit) + int'(err) != 1) begin
          failures++;
          $display("FAIL exclusive cyc=%0d got=%b%b%b want=one-hot", cyc, wr_en, commit, err);
        end else if (sbq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_strobe cyc=%0d got=kind%0d want=none", cyc, kind);
        end else begin
          e = sbq.pop_front();
          if (e.kind != kind || e.cyc != cyc) begin
            failures++;
            $display("FAIL strobe cyc=%0d got=kind%0d@%0d want=kind%0d@%0d", cyc, kind, cyc,
                     e.kind, e.cyc);
          end
        end
      end else if (sbq.size() != 0 && sbq[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_strobe cyc=%0d got=none want=kind%0d@%0d", cyc, sbq[0].kind,
                 sbq[0].cyc);
        void'(sbq.pop_front());
      end
    end
  end

  task automatic hold(input logic [11:0] v, input int n);
    repeat (n) begin
      key_in = v;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [11:0] v);
    hold(v, 5);
    hold('0, 6);
  endtask

  initial begin
    logic [11:0] v;
    int r, a, b;
    rst = 1'b0;
    hold('0, 3);
    rst = 1'b1;
    hold('0, 6);
    // '2' held 10 cycles
    hold(12'h002, 10);
    hold('0, 6);
    // '#' x3 then '5'
    repeat (3) press(12'h800);
    press(12'h010);
    // '#' x8 wraps the cursor
    repeat (8) press(12'h800);
    // '7' bouncing, then stable
    repeat (5) begin
      hold(12'h040, 2);
      hold('0, 2);
    end
    hold(12'h040, 6);
    hold('0, 6);
    // multi-key error, then commit
    hold(12'h003, 6);
    hold('0, 6);
    press(12'h400);
    // '9' held across reset
    rst = 1'b0;
    hold(12'h100, 3);
    rst = 1'b1;
    hold(12'h100, 10);
    hold('0, 6);
    press(12'h100);
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        rst = 1'b0;
        hold(12'(1 << $urandom_range(0, 11)), $urandom_range(1, 3));
        rst = 1'b1;
      end else if (r < 55) begin
        hold(12'(1 << $urandom_range(0, 11)), $urandom_range(1, 8));
      end else if (r < 65) begin
        a = $urandom_range(0, 11);
        b = (a + 1 + $urandom_range(0, 10)) % 12;
        v = 12'(1 << a) | 12'(1 << b);
        hold(v, $urandom_range(1, 8));
      end else begin
        hold('0, $urandom_range(1, 8));
      end
    end
    hold('0, 12);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending want=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
